// File: rtl/prio_enc_serial_if.sv
// Request/index handshake bundle for prio_enc_serial.
// slave: encoder side; master: producer/consumer side.
interface prio_enc_serial_if #(
  parameter int N_IN  = 8,
  parameter int IDX_W = 3
);
  logic [N_IN-1:0]  req_in;
  logic             req_vld;
  logic             req_rdy;
  logic [IDX_W-1:0] idx;
  logic             idx_vld;
  logic             idx_rdy;
  logic             none;
`ifdef PRIO_ENC_SERIAL_CNT_EN
  logic [IDX_W:0]   remain;
`endif

  modport slave (
    input  req_in,
    input  req_vld,
    output req_rdy,
    output idx,
    output idx_vld,
    input  idx_rdy,
`ifdef PRIO_ENC_SERIAL_CNT_EN
    output remain,
`endif
    output none
  );

  modport master (
    output req_in,
    output req_vld,
    input  req_rdy,
    input  idx,
    input  idx_vld,
    output idx_rdy,
`ifdef PRIO_ENC_SERIAL_CNT_EN
    input  remain,
`endif
    input  none
  );
endinterface

// File: rtl/prio_enc_serial.sv
// Serial priority encoder: emits each set bit index of a captured
// vector, highest first; an all-zero vector yields one "none" beat.
// Ports: clk, rst_n (sync, active-low), clr (sync abort),
//   bus (slave): req_in/req_vld/req_rdy in, idx/none/idx_vld/idx_rdy out.
// Macro PRIO_ENC_SERIAL_CNT_EN adds bus.remain (set bits left).
module prio_enc_serial #(
  parameter int N_IN  = 8,
  parameter int IDX_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic             clr,
  prio_enc_serial_if.slave bus
);

  if (N_IN < 2 || N_IN > 64) begin : g_bad_n
    $error("prio_enc_serial: N_IN out of range 2..64");
  end
  if (IDX_W != $clog2(N_IN)) begin : g_bad_w
    $error("prio_enc_serial: IDX_W must be clog2(N_IN)");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    EMPTY
  } state_t;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0] idx_c;
  logic [N_IN-1:0]  sel;

  // Later (higher) set bits overwrite earlier ones.
  always_comb begin
    idx_c = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (hold_q[i]) idx_c = IDX_W'(i);
    end
  end

  assign sel = N_IN'(1) << idx_c;

`ifdef PRIO_ENC_SERIAL_CNT_EN
  logic [IDX_W:0] remain_q, remain_d;
  logic [IDX_W:0] pcnt;

  always_comb begin
    pcnt = '0;
    for (int i = 0; i < N_IN; i++) begin
      pcnt = pcnt + (IDX_W+1)'(bus.req_in[i]);
    end
  end

  assign bus.remain = remain_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hold_q   <= '0;
`ifdef PRIO_ENC_SERIAL_CNT_EN
      remain_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
`ifdef PRIO_ENC_SERIAL_CNT_EN
      remain_q <= remain_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
`ifdef PRIO_ENC_SERIAL_CNT_EN
    remain_d = remain_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_vld) begin
          if (|bus.req_in) begin
            hold_d   = bus.req_in;
            state_d  = BUSY;
`ifdef PRIO_ENC_SERIAL_CNT_EN
            remain_d = pcnt;
`endif
          end else begin
            state_d = EMPTY;
          end
        end
      end
      BUSY: begin
        if (bus.idx_rdy) begin
          hold_d = hold_q & ~sel;
          if (hold_d == '0) state_d = IDLE;
`ifdef PRIO_ENC_SERIAL_CNT_EN
          remain_d = remain_q - 1'b1;
`endif
        end
      end
      EMPTY: begin
        if (bus.idx_rdy) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
    // Abort wins over any handshake in the same cycle.
    if (clr) begin
      state_d  = IDLE;
      hold_d   = '0;
`ifdef PRIO_ENC_SERIAL_CNT_EN
      remain_d = '0;
`endif
    end
  end

  assign bus.req_rdy = (state_q == IDLE);
  assign bus.idx_vld = (state_q == BUSY) || (state_q == EMPTY);
  assign bus.idx     = (state_q == BUSY) ? idx_c : '0;
  assign bus.none    = (state_q == EMPTY);

endmodule
